// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler and its arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } sched_state_t;

    localparam int UART_DW = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping around.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o,
    output logic               valid_o
);

    int cand;

    // Scan from the farthest offset down so the nearest valid index is written last and wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (req_i[IW'(cand)]) begin
                idx_o   = IW'(cand);
                valid_o = 1'b1;
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers,
// with per-frame parity latching, inter-frame gap and acknowledge timeout.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int GAP_CYCLES  = 2,
    parameter  int ACK_TIMEOUT = 4,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int GW          = 4,
    localparam int AW          = $clog2(ACK_TIMEOUT + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [UART_DW*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cfg_par_en,
    input  logic                       cfg_par_typ,
    output logic [UART_DW-1:0]         P_DATA,
    output logic                       DATA_VALID,
    output logic                       PAR_EN,
    output logic                       PAR_TYP,
    input  logic                       Busy,
    output logic [IW-1:0]              gnt_id,
    output logic                       frame_done,
    output logic                       err_timeout,
    input  logic                       err_clr
);

    sched_state_t       state_q, state_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [AW-1:0]      ack_q, ack_d;
    logic [UART_DW-1:0] p_data_q, p_data_d;
    logic               par_en_q, par_en_d;
    logic               par_typ_q, par_typ_d;
    logic [IW-1:0]      gnt_id_q, gnt_id_d;
    logic               err_q, err_d;

    logic [UART_DW-1:0] req_bytes [NUM_REQ];
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic               grant_ok;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[UART_DW*gi +: UART_DW];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Gated by reset so no grant can leak out while the block is held in reset.
    assign grant_ok   = reset && (state_q == S_IDLE) && (gap_q == '0) && !Busy && arb_valid;
    assign req_ready  = grant_ok ? arb_gnt : '0;
    assign DATA_VALID = (state_q == S_ISSUE);
    assign frame_done = (state_q == S_WAIT_DONE) && !Busy;

    assign P_DATA      = p_data_q;
    assign PAR_EN      = par_en_q;
    assign PAR_TYP     = par_typ_q;
    assign gnt_id      = gnt_id_q;
    assign err_timeout = err_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gap_d     = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
        ack_d     = ack_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        gnt_id_d  = gnt_id_q;
        err_d     = err_q & ~err_clr;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    p_data_d  = req_bytes[arb_idx];
                    par_en_d  = cfg_par_en;
                    par_typ_d = cfg_par_typ;
                    gnt_id_d  = arb_idx;
                    rr_ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ack_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (Busy) begin
                    state_d = S_WAIT_DONE;
                end else if (ack_q == AW'(ACK_TIMEOUT - 1)) begin
                    // The byte is dropped; a new timeout overrides a coincident clear.
                    err_d   = 1'b1;
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = S_IDLE;
                end else begin
                    ack_d = ack_q + AW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!Busy) begin
                    gap_d   = GW'(GAP_CYCLES);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gap_q     <= '0;
            ack_q     <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            gnt_id_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            gnt_id_q  <= gnt_id_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: expected frames are queued at stimulus time and
// checked when DATA_VALID fires; scenario tasks check grants, timing and flags inline.
module tb_uart_tx_sched;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_typ = 1'b0;
    logic [7:0]  P_DATA;
    logic        DATA_VALID, PAR_EN, PAR_TYP;
    logic        Busy;
    logic [1:0]  gnt_id;
    logic        frame_done, err_timeout;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       pe;
        logic       pt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [3:0] mon_oh;
    logic [3:0] prev_ready = '0;

    logic ack_en = 1'b1;
    logic busy_hold = 1'b0;
    logic busy_m;
    int   bcnt;

    assign Busy = busy_m | busy_hold;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .NUM_REQ     (4),
        .GAP_CYCLES  (2),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cfg_par_en  (cfg_par_en),
        .cfg_par_typ (cfg_par_typ),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Busy        (Busy),
        .gnt_id      (gnt_id),
        .frame_done  (frame_done),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    // Transmitter model: Busy rises the edge after DATA_VALID and stays high 11 cycles.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            bcnt   <= 0;
        end else if (DATA_VALID && ack_en) begin
            busy_m <= 1'b1;
            bcnt   <= 11;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            bcnt   <= 0;
            busy_m <= 1'b0;
        end
    end

    // Output monitor: one-hot grants every cycle, frame fields and 1-cycle latency at DATA_VALID.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            n_checks++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot: req_ready=%b, required at most one bit set", req_ready);
            end
            if (DATA_VALID) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: DATA_VALID with P_DATA=%h, required no frame", P_DATA);
                end else begin
                    mon_e  = sb_q.pop_front();
                    mon_oh = 4'b0001 << mon_e.id;
                    if ({gnt_id, P_DATA, PAR_EN, PAR_TYP} !== mon_e) begin
                        n_fail++;
                        $display("FAIL frame_fields: id=%0d data=%h pe=%b pt=%b, required id=%0d data=%h pe=%b pt=%b",
                                 gnt_id, P_DATA, PAR_EN, PAR_TYP, mon_e.id, mon_e.data, mon_e.pe, mon_e.pt);
                    end
                    n_checks++;
                    if (prev_ready !== mon_oh) begin
                        n_fail++;
                        $display("FAIL grant_latency: req_ready one cycle before DATA_VALID=%b, required %b",
                                 prev_ready, mon_oh);
                    end
                end
            end
            $display("cycle t=%0t ready=%b dv=%b data=%h busy=%b done=%b err=%b",
                     $time, req_ready, DATA_VALID, P_DATA, Busy, frame_done, err_timeout);
            prev_ready = req_ready;
        end else begin
            prev_ready = '0;
        end
    end

    task automatic apply_reset();
        reset     = 1'b0;
        req_valid = '0;
        err_clr   = 1'b0;
        ack_en    = 1'b1;
        busy_hold = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready(input int max, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        #1;
        while (!ok && waited < max) begin
            if (req_ready != '0) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
                waited++;
            end
        end
    endtask

    task automatic wait_done(input int max, output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        #1;
        while (!ok && waited < max) begin
            if (frame_done) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
                waited++;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b1111;
        @(negedge clk);
        #1;
        n_checks++;
        if ({P_DATA, DATA_VALID, PAR_EN, PAR_TYP, gnt_id, frame_done, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: data=%h dv=%b pe=%b pt=%b id=%0d done=%b err=%b, required all 0",
                     P_DATA, DATA_VALID, PAR_EN, PAR_TYP, gnt_id, frame_done, err_timeout);
        end
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: req_ready=%b while in reset, required 0000", req_ready);
        end
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int w; bit ok;
        apply_reset();
        req_data[7:0] = 8'hA5;
        cfg_par_en  = 1'b1;
        cfg_par_typ = 1'b0;
        sb_q.push_back('{id: 2'd0, data: 8'hA5, pe: 1'b1, pt: 1'b0});
        req_valid = 4'b0001;
        wait_ready(20, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0001 || w != 0) begin
            n_fail++;
            $display("FAIL single_grant: req_ready=%b after %0d cycles, required 0001 after 0", req_ready, w);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (DATA_VALID !== 1'b1 || req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_issue: DATA_VALID=%b req_ready=%b, required 1 and 0000", DATA_VALID, req_ready);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (DATA_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL single_dv_pulse: DATA_VALID=%b one cycle later, required 0", DATA_VALID);
        end
        wait_done(40, w, ok);
        n_checks++;
        if (!ok || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: frame_done seen=%b Busy=%b, required 1 and 0", ok, Busy);
        end
        req_data[7:0] = 8'h5A;
        sb_q.push_back('{id: 2'd0, data: 8'h5A, pe: 1'b1, pt: 1'b0});
        req_valid = 4'b0001;
        wait_ready(20, w, ok);
        n_checks++;
        if (!ok || w != 3) begin
            n_fail++;
            $display("FAIL gap_length: next grant %0d cycles after frame_done, required 3", w);
        end
        @(negedge clk);
        req_valid = '0;
        wait_done(40, w, ok);
    endtask

    task automatic test_fairness();
        int w; bit ok;
        logic [3:0] exp_oh;
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        apply_reset();
        req_data    = 32'h44332211;
        cfg_par_en  = 1'b0;
        cfg_par_typ = 1'b1;
        for (int i = 0; i < 5; i++)
            sb_q.push_back('{id: 2'(i % 4), data: bytes[i % 4], pe: 1'b0, pt: 1'b1});
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_oh = 4'b0001 << (i % 4);
            wait_ready(60, w, ok);
            n_checks++;
            if (!ok || req_ready !== exp_oh) begin
                n_fail++;
                $display("FAIL fair_order_%0d: req_ready=%b, required %b", i, req_ready, exp_oh);
            end
            @(negedge clk);
            if (i == 4) req_valid = '0;
        end
        wait_done(60, w, ok);
    endtask

    task automatic test_wrap_skip();
        int w; bit ok;
        apply_reset();
        req_data = 32'hDDCCBBAA;
        sb_q.push_back('{id: 2'd2, data: 8'hCC, pe: cfg_par_en, pt: cfg_par_typ});
        req_valid = 4'b0100;
        wait_ready(20, w, ok);
        @(negedge clk);
        req_valid = '0;
        wait_done(60, w, ok);
        repeat (3) @(negedge clk);
        sb_q.push_back('{id: 2'd0, data: 8'hAA, pe: cfg_par_en, pt: cfg_par_typ});
        sb_q.push_back('{id: 2'd2, data: 8'hCC, pe: cfg_par_en, pt: cfg_par_typ});
        req_valid = 4'b0101;
        wait_ready(20, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant: req_ready=%b with ptr=3, required 0001", req_ready);
        end
        @(negedge clk);
        wait_ready(60, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL skip_grant: req_ready=%b with ptr=1, required 0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_done(60, w, ok);
    endtask

    task automatic test_cfg_stable();
        int w; bit ok; bit seen;
        apply_reset();
        cfg_par_en  = 1'b1;
        cfg_par_typ = 1'b1;
        req_data[15:8] = 8'h5C;
        sb_q.push_back('{id: 2'd1, data: 8'h5C, pe: 1'b1, pt: 1'b1});
        req_valid = 4'b0010;
        wait_ready(20, w, ok);
        @(negedge clk);
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cfg_par_typ = ~cfg_par_typ;
            cfg_par_en  = ~cfg_par_en;
            #1;
            n_checks++;
            if (PAR_TYP !== 1'b1 || PAR_EN !== 1'b1) begin
                n_fail++;
                $display("FAIL cfg_stable: PAR_EN=%b PAR_TYP=%b mid-frame, required 1 and 1", PAR_EN, PAR_TYP);
            end
            if (frame_done) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL cfg_frame_end: frame_done=0 after 40 cycles, required 1");
        end
        cfg_par_en  = 1'b0;
        cfg_par_typ = 1'b0;
    endtask

    task automatic test_timeout();
        int w; bit ok;
        apply_reset();
        ack_en = 1'b0;
        req_data = 32'h00006B3E;
        sb_q.push_back('{id: 2'd0, data: 8'h3E, pe: 1'b0, pt: 1'b0});
        sb_q.push_back('{id: 2'd1, data: 8'h6B, pe: 1'b0, pt: 1'b0});
        req_valid = 4'b0011;
        wait_ready(20, w, ok);
        @(negedge clk);
        req_valid = 4'b0010;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: err_timeout=%b after 3 wait cycles, required 0", err_timeout);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_set: err_timeout=%b after 4 wait cycles, required 1", err_timeout);
        end
        ack_en = 1'b1;
        wait_ready(20, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0010 || w != 2) begin
            n_fail++;
            $display("FAIL timeout_next: req_ready=%b after %0d cycles, required 0010 after 2", req_ready, w);
        end
        @(negedge clk);
        req_valid = '0;
        wait_done(60, w, ok);
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err_timeout=%b after a good frame, required 1", err_timeout);
        end
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_checks++;
        if (err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err_timeout=%b after err_clr, required 0", err_timeout);
        end
    endtask

    task automatic test_holdoff();
        int w; bit ok;
        apply_reset();
        busy_hold = 1'b1;
        req_data[7:0] = 8'hC3;
        sb_q.push_back('{id: 2'd0, data: 8'hC3, pe: cfg_par_en, pt: cfg_par_typ});
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL holdoff: req_ready=%b while Busy held, required 0000", req_ready);
            end
            @(negedge clk);
        end
        busy_hold = 1'b0;
        wait_ready(5, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0001 || w != 0) begin
            n_fail++;
            $display("FAIL holdoff_release: req_ready=%b after %0d cycles, required 0001 after 0", req_ready, w);
        end
        @(negedge clk);
        req_valid = '0;
        wait_done(60, w, ok);
    endtask

    task automatic test_reset_mid();
        int w; bit ok;
        apply_reset();
        cfg_par_en  = 1'b1;
        cfg_par_typ = 1'b1;
        req_data = 32'h00770000;
        sb_q.push_back('{id: 2'd2, data: 8'h77, pe: 1'b1, pt: 1'b1});
        req_valid = 4'b0100;
        wait_ready(20, w, ok);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (Busy !== 1'b1 || gnt_id !== 2'd2) begin
            n_fail++;
            $display("FAIL mid_frame_setup: Busy=%b gnt_id=%0d, required 1 and 2", Busy, gnt_id);
        end
        #2;
        reset = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if ({P_DATA, DATA_VALID, PAR_EN, PAR_TYP, req_ready, gnt_id, frame_done, err_timeout} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: data=%h dv=%b pe=%b pt=%b ready=%b id=%0d done=%b err=%b, required all 0",
                     P_DATA, DATA_VALID, PAR_EN, PAR_TYP, req_ready, gnt_id, frame_done, err_timeout);
        end
        @(negedge clk);
        req_data = 32'h44332211;
        sb_q.push_back('{id: 2'd0, data: 8'h11, pe: 1'b1, pt: 1'b1});
        reset = 1'b1;
        wait_ready(20, w, ok);
        n_checks++;
        if (!ok || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: req_ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        wait_done(60, w, ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap_skip();
        test_cfg_stable();
        test_timeout();
        test_holdoff();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames never issued, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among NUM_REQ byte producers.
- Captures one byte per grant and latches that frame's parity configuration.
- Issues a single-cycle DATA_VALID to the transmitter, then tracks Busy until the frame ends.
- Enforces a programmable inter-frame gap and flags a transmitter that never acknowledges.
- Sits between the requester logic and the UART TX inside the UART wrapper.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- GAP_CYCLES, 2: idle cycles forced after Busy falls before the next grant, 0..15.
- ACK_TIMEOUT, 4: cycles to wait for Busy to rise after DATA_VALID before flagging an error, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant pulse; the byte is consumed in this cycle.
- cfg_par_en  in  1  parity enable, sampled at grant.
- cfg_par_typ  in  1  parity type (0 even, 1 odd), sampled at grant.
- P_DATA  out  8  byte to the transmitter.
- DATA_VALID  out  1  single-cycle start strobe to the transmitter.
- PAR_EN  out  1  latched parity enable, stable for the whole frame.
- PAR_TYP  out  1  latched parity type, stable for the whole frame.
- Busy  in  1  transmitter busy.
- gnt_id  out  $clog2(NUM_REQ)  index of the last granted requester.
- frame_done  out  1  one-cycle pulse when Busy falls.
- err_timeout  out  1  sticky acknowledge-timeout flag.
- err_clr  in  1  clears err_timeout.

Behaviour:
- Reset (asynchronous, reset=0) drives these values:
  - outputs: P_DATA=0, DATA_VALID=0, PAR_EN=0, PAR_TYP=0, req_ready=0, gnt_id=0, frame_done=0, err_timeout=0;
  - internal: state=S_IDLE, rr_ptr=0, gap counter=0.
  - Reset asserted mid-frame aborts the frame; the transmitter is reset by the same signal.
- S_IDLE: grants only when gap counter==0, Busy==0 and at least one req_valid is set.
  - Searches from rr_ptr upward with wrap-around; the first valid index k wins.
  - Same cycle: req_ready[k]=1 (combinational from registered state and req_valid).
  - Next edge: P_DATA<=req_data[k], PAR_EN<=cfg_par_en, PAR_TYP<=cfg_par_typ, gnt_id<=k, rr_ptr<=(k+1) mod NUM_REQ, state<=S_ISSUE.
- S_ISSUE: DATA_VALID=1 for exactly this cycle; next state S_WAIT_ACK with the ack counter cleared.
- S_WAIT_ACK: Busy==1 moves to S_WAIT_DONE.
  - Otherwise the ack counter increments.
  - When it reaches ACK_TIMEOUT: set err_timeout, load the gap counter with GAP_CYCLES, return to S_IDLE. The byte is dropped, not retried.
- S_WAIT_DONE: Busy==0 pulses frame_done, loads the gap counter with GAP_CYCLES and returns to S_IDLE.
- Gap counter decrements each cycle while nonzero. GAP_CYCLES=0 allows a grant in the cycle after frame_done.
- P_DATA, PAR_EN and PAR_TYP change only on grant. cfg_* changes mid-frame have no effect until the next grant.
- At most one req_ready per cycle. Latency from req_valid (idle, gap expired) to DATA_VALID is 1 cycle.
- A requester that drops req_valid before its grant loses its turn, with no side effects.
- Simultaneous err_clr and a new timeout: set wins.
- Busy==1 while in S_IDLE (external holdoff) blocks grants.

Decomposition:
- Shared package uart_pkg holds:
  - the enum sched_state_t {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE};
  - the byte-width constant UART_DW=8;
  - the parity type constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module, rr_arbiter: combinational round-robin picker taking req and ptr and returning a one-hot grant plus its index; parameterised by NUM_REQ.

Test Plan:
- Single requester: req_valid=4'b0001, req_data[7:0]=8'hA5, cfg_par_en=1, cfg_par_typ=0, transmitter model raises Busy 1 cycle after DATA_VALID and holds it 11 cycles -> req_ready=0001 for one cycle, DATA_VALID one cycle later with P_DATA=A5, PAR_EN=1, PAR_TYP=0, frame_done on Busy fall, next grant ≥3 cycles later.
- Fairness: all four requesters valid continuously, bytes 11/22/33/44 -> grant order 0,1,2,3,0 and P_DATA sequence 11,22,33,44,11; gnt_id tracks the order.
- Wrap and skip: rr_ptr=3, req_valid=4'b0101 -> requester 0 granted, rr_ptr becomes 1; next grant goes to requester 2.
- Config stability: cfg_par_typ toggles every cycle during a frame -> PAR_TYP constant, equal to its value at grant.
- Timeout: Busy held 0 after DATA_VALID -> err_timeout=1 after 4 wait cycles, return to idle, next requester served; err_clr pulse -> err_timeout=0.
- Reset mid-frame: reset low during S_WAIT_DONE -> all outputs at reset values immediately; after release, first grant goes to requester 0.
